// File: rtl/oled_fmt_pkg.sv
// Shared definitions for the OLED result formatter: FSM states, line column
// positions, ASCII codes and the printable-character filter.
package oled_fmt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    // Column positions on the 16-character line
    localparam logic [3:0] COL_OP0  = 4'd0;   // first opcode character
    localparam logic [3:0] COL_SP0  = 4'd4;   // separator between opcode and value
    localparam logic [3:0] COL_HEX0 = 4'd7;   // most significant hex digit
    localparam logic [3:0] COL_LAST = 4'd15;  // trailing space, end of line

    // ASCII codes used to build the line
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_A     = 8'h41;
    localparam logic [7:0] ASCII_X     = 8'h78;

    // Opcode bytes outside the printable range would confuse the character
    // driver, so they are shown as a blank instead.
    function automatic logic [7:0] printable_or_space(input logic [7:0] b);
        logic [7:0] r;
        if ((b >= 8'h20) && (b <= 8'h7E)) begin
            r = b;
        end else begin
            r = ASCII_SPACE;
        end
        return r;
    endfunction

endpackage

// File: rtl/oled_result_formatter_nibble_to_ascii.sv
// nibble_to_ascii: combinational 4-bit value to uppercase hex ASCII digit.
module nibble_to_ascii
    import oled_fmt_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [7:0] o_ascii
);

    // Digits 0-9 map onto '0'..'9', 10-15 onto 'A'..'F'
    always_comb begin
        if (i_nibble < 4'd10) begin
            o_ascii = ASCII_0 + {4'd0, i_nibble};
        end else begin
            o_ascii = ASCII_A + {4'd0, i_nibble} - 8'd10;
        end
    end

endmodule

// File: rtl/oled_result_formatter.sv
// oled_result_formatter: prints the held result word and 4-byte opcode text as
// one 16-character ASCII line, one character per valid/ready handshake.
// A frame starts after reset and whenever either input word changes; a change
// seen mid-frame is remembered and printed as a single follow-up frame.
// Line: "OOOO 0xHHHHHHHH " (opcode, space, "0x", 8 hex digits, space).
// Optional build macro OLED_FMT_ZERO_BLANK_EN: leading zero hex digits in
// columns 7-13 print as spaces; column 14 always prints a digit.
module oled_result_formatter
    import oled_fmt_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] OLED_data,
    input  logic [31:0] OLED_opcode_disp,
    input  logic        char_ready,
    output logic [7:0]  char_out,
    output logic [3:0]  char_col,
    output logic        char_valid,
    output logic        busy,
    output logic        frame_done
);

    // Registered state
    state_t      r_state;
    logic [31:0] r_snap_data;
    logic [31:0] r_snap_op;
    logic        r_pending;
    logic [3:0]  r_col;
    logic [7:0]  r_char_out;
    logic        r_char_valid;
    logic        r_busy;
    logic        r_frame_done;

    // Next-state and datapath wires
    state_t      w_state_nxt;
    logic [3:0]  w_col_nxt;
    logic        w_pending_nxt;
    logic        w_busy_nxt;
    logic        w_frame_done_nxt;
    logic        w_capture;
    logic        w_change;
    logic [31:0] w_data_nxt;
    logic [31:0] w_op_nxt;
    logic [3:0]  w_hex_idx;
    logic [3:0]  w_nibble;
    logic [7:0]  w_hex_char;
    logic [7:0]  w_digit_char;
    logic [7:0]  w_char_fmt;
    logic [7:0]  w_char_out_nxt;

    // Either input word differs from what was last captured for printing
    assign w_change = (OLED_data != r_snap_data) || (OLED_opcode_disp != r_snap_op);

    // Frame sequencing: start, per-character advance, completion, change tracking
    always_comb begin
        w_state_nxt      = r_state;
        w_col_nxt        = r_col;
        w_pending_nxt    = r_pending;
        w_busy_nxt       = r_busy;
        w_frame_done_nxt = 1'b0;
        w_capture        = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_pending || w_change) begin
                    w_state_nxt   = SEND;
                    w_capture     = 1'b1;
                    w_col_nxt     = COL_OP0;
                    w_pending_nxt = 1'b0;
                    w_busy_nxt    = 1'b1;
                end else begin
                    w_busy_nxt    = 1'b0;
                end
            end
            SEND: begin
                // A change during the frame is only remembered; the frame in
                // flight keeps printing the snapshot.
                w_pending_nxt = r_pending | w_change;
                if (r_char_valid && char_ready) begin
                    if (r_col == COL_LAST) begin
                        w_state_nxt      = DONE;
                        w_frame_done_nxt = 1'b1;
                    end else begin
                        w_col_nxt = r_col + 4'd1;
                    end
                end else begin
                    w_state_nxt = SEND;
                end
            end
            DONE: begin
                w_pending_nxt = r_pending | w_change;
                w_state_nxt   = IDLE;
                w_busy_nxt    = 1'b0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // Snapshot values as they will be after this edge; the output character
    // is formatted from these so it is ready in the same cycle valid rises.
    assign w_data_nxt = w_capture ? OLED_data        : r_snap_data;
    assign w_op_nxt   = w_capture ? OLED_opcode_disp : r_snap_op;

    // Hex digit position 0..7 counted from the most significant nibble
    assign w_hex_idx = w_col_nxt - COL_HEX0;

    // Select the nibble shown at the upcoming hex column
    always_comb begin
        case (w_hex_idx)
            4'd0:    w_nibble = w_data_nxt[31:28];
            4'd1:    w_nibble = w_data_nxt[27:24];
            4'd2:    w_nibble = w_data_nxt[23:20];
            4'd3:    w_nibble = w_data_nxt[19:16];
            4'd4:    w_nibble = w_data_nxt[15:12];
            4'd5:    w_nibble = w_data_nxt[11:8];
            4'd6:    w_nibble = w_data_nxt[7:4];
            4'd7:    w_nibble = w_data_nxt[3:0];
            default: w_nibble = 4'd0;
        endcase
    end

    nibble_to_ascii u_nibble_to_ascii (
        .i_nibble (w_nibble),
        .o_ascii  (w_hex_char)
    );

`ifdef OLED_FMT_ZERO_BLANK_EN
    logic w_lead_zero;

    // A digit is blanked when it and every more significant nibble are zero;
    // the least significant digit is never blanked so zero still shows.
    always_comb begin
        case (w_hex_idx)
            4'd0:    w_lead_zero = (w_data_nxt[31:28] == 4'd0);
            4'd1:    w_lead_zero = (w_data_nxt[31:24] == 8'd0);
            4'd2:    w_lead_zero = (w_data_nxt[31:20] == 12'd0);
            4'd3:    w_lead_zero = (w_data_nxt[31:16] == 16'd0);
            4'd4:    w_lead_zero = (w_data_nxt[31:12] == 20'd0);
            4'd5:    w_lead_zero = (w_data_nxt[31:8]  == 24'd0);
            4'd6:    w_lead_zero = (w_data_nxt[31:4]  == 28'd0);
            default: w_lead_zero = 1'b0;
        endcase
    end

    assign w_digit_char = w_lead_zero ? ASCII_SPACE : w_hex_char;
`else
    assign w_digit_char = w_hex_char;
`endif

    // Build the character for the upcoming column of the line layout
    always_comb begin
        case (w_col_nxt)
            COL_OP0:  w_char_fmt = printable_or_space(w_op_nxt[31:24]);
            4'd1:     w_char_fmt = printable_or_space(w_op_nxt[23:16]);
            4'd2:     w_char_fmt = printable_or_space(w_op_nxt[15:8]);
            4'd3:     w_char_fmt = printable_or_space(w_op_nxt[7:0]);
            COL_SP0:  w_char_fmt = ASCII_SPACE;
            4'd5:     w_char_fmt = ASCII_0;
            4'd6:     w_char_fmt = ASCII_X;
            COL_LAST: w_char_fmt = ASCII_SPACE;
            default:  w_char_fmt = w_digit_char;
        endcase
    end

    // Only load a new character while a frame is being sent; otherwise hold
    assign w_char_out_nxt = (w_state_nxt == SEND) ? w_char_fmt : r_char_out;

    // State, snapshot and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_snap_data  <= 32'd0;
            r_snap_op    <= 32'd0;
            r_pending    <= 1'b1;
            r_col        <= 4'd0;
            r_char_out   <= 8'd0;
            r_char_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_snap_data  <= w_data_nxt;
            r_snap_op    <= w_op_nxt;
            r_pending    <= w_pending_nxt;
            r_col        <= w_col_nxt;
            r_char_out   <= w_char_out_nxt;
            r_char_valid <= (w_state_nxt == SEND);
            r_busy       <= w_busy_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    assign char_out   = r_char_out;
    assign char_col   = r_col;
    assign char_valid = r_char_valid;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_oled_result_formatter.sv
// Directed self-checking bench for oled_result_formatter. Expected lines are
// written out by hand for both the default and OLED_FMT_ZERO_BLANK_EN builds.
module tb_oled_result_formatter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] OLED_data;
    logic [31:0] OLED_opcode_disp;
    logic        char_ready;
    logic [7:0]  char_out;
    logic [3:0]  char_col;
    logic        char_valid;
    logic        busy;
    logic        frame_done;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    oled_result_formatter dut (
        .clk              (clk),
        .rst              (rst),
        .OLED_data        (OLED_data),
        .OLED_opcode_disp (OLED_opcode_disp),
        .char_ready       (char_ready),
        .char_out         (char_out),
        .char_col         (char_col),
        .char_valid       (char_valid),
        .busy             (busy),
        .frame_done       (frame_done)
    );

    localparam logic [127:0] L_MUL  = "MUL  0xDEADBEEF ";
    localparam logic [127:0] L_AB   = "  AB 0xFFFFFFFF ";
    localparam logic [127:0] L_RSET = "RSET 0x12345678 ";
`ifdef OLED_FMT_ZERO_BLANK_EN
    localparam logic [127:0] L_START = "     0x       0 ";
    localparam logic [127:0] L_ADD   = "ADD  0x    1234 ";
    localparam logic [127:0] L_MOV1  = "MOV  0x       1 ";
    localparam logic [127:0] L_MOV3  = "MOV  0x       3 ";
    localparam logic [127:0] L_NOOP  = "noop 0x      A5 ";
`else
    localparam logic [127:0] L_START = "     0x00000000 ";
    localparam logic [127:0] L_ADD   = "ADD  0x00001234 ";
    localparam logic [127:0] L_MOV1  = "MOV  0x00000001 ";
    localparam logic [127:0] L_MOV3  = "MOV  0x00000003 ";
    localparam logic [127:0] L_NOOP  = "noop 0x000000A5 ";
`endif

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Receive one line. Called at a sample point (#1 after a rising edge);
    // returns at the sample point where frame_done is seen after column 15.
    task automatic collect(input bit toggle,
                           input int chg_col_a, input logic [31:0] chg_val_a,
                           input int chg_col_b, input logic [31:0] chg_val_b,
                           output logic [127:0] line, output int edges,
                           output int vcyc, output bit stable_ok,
                           output int first_col, output bit timed_out);
        bit         got15     = 1'b0;
        bit         last_stall = 1'b0;
        bit         done_a    = 1'b0;
        bit         done_b    = 1'b0;
        logic [7:0] held_c    = 8'd0;
        logic [3:0] held_col  = 4'd0;
        line      = '0;
        edges     = 0;
        vcyc      = 0;
        stable_ok = 1'b1;
        first_col = -1;
        timed_out = 1'b1;
        for (int k = 0; k < 200; k++) begin
            if (got15 && frame_done) begin
                timed_out = 1'b0;
                break;
            end
            if (last_stall) begin
                if (!char_valid || char_out !== held_c || char_col !== held_col)
                    stable_ok = 1'b0;
            end
            last_stall = 1'b0;
            if (char_valid) begin
                if (first_col < 0) first_col = int'(char_col);
                if (!done_a && int'(char_col) == chg_col_a) begin
                    OLED_data = chg_val_a;
                    done_a = 1'b1;
                end
                if (!done_b && int'(char_col) == chg_col_b) begin
                    OLED_data = chg_val_b;
                    done_b = 1'b1;
                end
                if (toggle) char_ready = (vcyc % 2 == 1);
                vcyc++;
                if (char_ready) begin
                    line[8*(15 - int'(char_col)) +: 8] = char_out;
                    if (char_col == 4'd15) got15 = 1'b1;
                end else begin
                    last_stall = 1'b1;
                    held_c     = char_out;
                    held_col   = char_col;
                end
            end
            @(posedge clk); #1;
            edges++;
        end
    endtask

    // One edge after frame_done: pulse gone, back in IDLE, nothing sent
    task automatic post_frame(input string tag);
        @(posedge clk); #1;
        check({tag, "_fd_pulse"}, 128'(frame_done), 128'(1'b0));
        check({tag, "_busy_off"}, 128'(busy), 128'(1'b0));
        check({tag, "_valid_off"}, 128'(char_valid), 128'(1'b0));
    endtask

    initial begin
        logic [127:0] line;
        int           edges;
        int           vcyc;
        bit           stable_ok;
        int           first_col;
        bit           tmo;
        int           seen;
        bit           found;

        rst = 1'b1;
        OLED_data = 32'd0;
        OLED_opcode_disp = 32'd0;
        char_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_char_out", 128'(char_out), 128'(8'd0));
        check("rst_char_col", 128'(char_col), 128'(4'd0));
        check("rst_valid", 128'(char_valid), 128'(1'b0));
        check("rst_busy", 128'(busy), 128'(1'b0));
        check("rst_frame_done", 128'(frame_done), 128'(1'b0));

        // Startup frame from the reset snapshot
        rst = 1'b0;
        collect(1'b0, -1, 32'd0, -1, 32'd0, line, edges, vcyc, stable_ok, first_col, tmo);
        check("start_timeout", 128'(tmo), 128'(1'b0));
        check("start_line", line, L_START);
        check("start_edges", 128'(edges), 128'(17));
        check("start_vcyc", 128'(vcyc), 128'(16));
        check("start_busy_at_done", 128'(busy), 128'(1'b1));
        post_frame("start");

        // Plain ADD frame, full speed
        OLED_opcode_disp = 32'h41444400;
        OLED_data = 32'h00001234;
        collect(1'b0, -1, 32'd0, -1, 32'd0, line, edges, vcyc, stable_ok, first_col, tmo);
        check("add_timeout", 128'(tmo), 128'(1'b0));
        check("add_line", line, L_ADD);
        check("add_edges", 128'(edges), 128'(17));
        check("add_first_col", 128'(first_col), 128'(0));
        post_frame("add");

        // Backpressure: ready low on the first valid cycle, then alternating
        char_ready = 1'b0;
        OLED_opcode_disp = 32'h4D554C20;
        OLED_data = 32'hDEADBEEF;
        collect(1'b1, -1, 32'd0, -1, 32'd0, line, edges, vcyc, stable_ok, first_col, tmo);
        char_ready = 1'b1;
        check("mul_timeout", 128'(tmo), 128'(1'b0));
        check("mul_line", line, L_MUL);
        check("mul_vcyc", 128'(vcyc), 128'(32));
        check("mul_stable", 128'(stable_ok), 128'(1'b1));
        post_frame("mul");

        // Mid-frame changes: 1 -> 2 at column 5, 2 -> 3 at column 9
        OLED_opcode_disp = 32'h4D4F5620;
        OLED_data = 32'h00000001;
        collect(1'b0, 5, 32'h00000002, 9, 32'h00000003, line, edges, vcyc, stable_ok, first_col, tmo);
        check("mid1_timeout", 128'(tmo), 128'(1'b0));
        check("mid1_line", line, L_MOV1);
        collect(1'b0, -1, 32'd0, -1, 32'd0, line, edges, vcyc, stable_ok, first_col, tmo);
        check("mid2_timeout", 128'(tmo), 128'(1'b0));
        check("mid2_line", line, L_MOV3);
        check("mid2_edges", 128'(edges), 128'(18));
        post_frame("mid2");
        seen = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (char_valid) seen++;
        end
        check("mid_no_third_frame", 128'(seen), 128'(0));

        // Printable opcode passes through unchanged
        OLED_opcode_disp = 32'h6E6F6F70;
        OLED_data = 32'h000000A5;
        collect(1'b0, -1, 32'd0, -1, 32'd0, line, edges, vcyc, stable_ok, first_col, tmo);
        check("noop_timeout", 128'(tmo), 128'(1'b0));
        check("noop_line", line, L_NOOP);
        post_frame("noop");

        // Control characters 0x0A and 0x7F become spaces
        OLED_opcode_disp = 32'h0A7F4142;
        OLED_data = 32'hFFFFFFFF;
        collect(1'b0, -1, 32'd0, -1, 32'd0, line, edges, vcyc, stable_ok, first_col, tmo);
        check("ab_timeout", 128'(tmo), 128'(1'b0));
        check("ab_line", line, L_AB);
        post_frame("ab");

        // Reset while column 8 is on the bus
        OLED_opcode_disp = 32'h52534554;
        OLED_data = 32'h12345678;
        found = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (char_valid && char_col == 4'd8) begin
                found = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("rst_mid_reach_col8", 128'(found), 128'(1'b1));
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_valid", 128'(char_valid), 128'(1'b0));
        check("rst_mid_frame_done", 128'(frame_done), 128'(1'b0));
        check("rst_mid_busy", 128'(busy), 128'(1'b0));
        rst = 1'b0;
        collect(1'b0, -1, 32'd0, -1, 32'd0, line, edges, vcyc, stable_ok, first_col, tmo);
        check("rst_new_timeout", 128'(tmo), 128'(1'b0));
        check("rst_new_first_col", 128'(first_col), 128'(0));
        check("rst_new_line", line, L_RSET);
        check("rst_new_edges", 128'(edges), 128'(17));
        post_frame("rst_new");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/oled_result_formatter.md
# oled_result_formatter

Downstream of the slave processing FSM. Turns its held 32-bit result word and 4-byte opcode text into one 16-character ASCII line for the OLED character driver. Each character leaves on a valid/ready handshake. A new frame starts on reset and whenever either input word changes, so the upstream FSM needs no strobe.

## Interface
- No parameters. Line length is fixed at 16 columns.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `OLED_data`  in  32  result word from the processing FSM, held between updates.
- `OLED_opcode_disp`  in  32  opcode text, 4 ASCII bytes, byte [31:24] first.
- `char_ready`  in  1  OLED driver accepts the current character.
- `char_out`  out  8  ASCII character.
- `char_col`  out  4  column of `char_out` (0–15).
- `char_valid`  out  1  `char_out`/`char_col` valid.
- `busy`  out  1  frame in progress.
- `frame_done`  out  1  one-cycle pulse after column 15 is accepted.

## Operation
- Snapshot registers `snap_data` and `snap_op` hold the words being printed. A `pending` flag records a change that arrives mid-frame.
- States:
  - IDLE: if `pending`, or either input differs from its snapshot, capture both inputs into the snapshots, clear `pending`, set column 0 and go to SEND.
  - SEND: assert `char_valid`. On `char_valid & char_ready`:
    - column < 15: increment the column.
    - column = 15: go to DONE.
  - DONE: pulse `frame_done`, go to IDLE.
- Line layout by column:
  - 0–3: opcode bytes [31:24], [23:16], [15:8], [7:0]. Any byte outside 0x20–0x7E is replaced by 0x20 (space).
  - 4: 0x20 (space).
  - 5–6: "0x" (0x30, 0x78).
  - 7–14: hex digits of `snap_data`, nibble [31:28] first. Nibble 0–9 → 0x30+n; nibble A–F → 0x41+(n−10), uppercase.
  - 15: 0x20 (space).
- While in SEND or DONE, if either input differs from its snapshot, set `pending`. The frame in flight completes unchanged from the snapshots. Exactly one follow-up frame is then printed with the input values present on the IDLE capture cycle; intermediate values are dropped.
- While `char_valid` is high, `char_out` and `char_col` stay stable until accepted. `char_valid` never drops without a handshake except on `rst`.
- Reset values:
  - `char_out`=0, `char_col`=0, `char_valid`=0, `busy`=0, `frame_done`=0.
  - Snapshots = 0, `pending`=1, so a startup frame is always printed.
- Reset mid-frame aborts the frame immediately; no `frame_done` is pulsed.

## Timing
- Inputs changing, sampled at edge N in IDLE: capture at N, `char_valid`=1 with column 0 from edge N+1.
- With `char_ready` tied high: one character per cycle; the last transfer is at edge N+16 and `frame_done` is high during cycle N+17.
- `busy`=1 from the cycle after capture through the `frame_done` cycle inclusive.
- Minimum spacing between frames is 2 cycles (DONE, then IDLE).
- A change and column 15 being accepted on the same edge: `pending` is set, and the next frame starts from IDLE.
- `char_ready` asserted while `char_valid`=0 is ignored.

## Configuration
- `OLED_FMT_ZERO_BLANK_EN` defined:
  - Leading zero hex digits in columns 7–13 print as 0x20.
  - Column 14 always prints a digit.
  - The first nonzero nibble and everything after it prints normally.
- Not defined: all 8 digits print, including leading zeros.
- The column count and timing are identical in both builds.

## Structure
- Shared package `oled_fmt_pkg` holds:
  - the state enum (IDLE, SEND, DONE);
  - column constants (`COL_OP0`=0, `COL_SP0`=4, `COL_HEX0`=7, `COL_LAST`=15);
  - ASCII constants (`ASCII_SPACE`=0x20, `ASCII_0`=0x30, `ASCII_A`=0x41, `ASCII_X`=0x78).
- One sub-module, `nibble_to_ascii`: combinational 4-bit → 8-bit converter, instantiated once on a column-selected nibble mux.

## Test plan
- Startup: release `rst` with inputs 0 and `char_ready`=1. Required line is "\x20\x20\x20\x20 0x00000000 ", with `frame_done` at cycle 17.
- ADD: `OLED_opcode_disp`=0x41444400, `OLED_data`=0x00001234, `char_ready`=1. Required line is "ADD  0x00001234 ". With `OLED_FMT_ZERO_BLANK_EN`: "ADD  0x    1234 ".
- Backpressure: MUL with 0xDEADBEEF, `char_ready` toggling 1/0 every cycle. Required line is "MUL  0xDEADBEEF ". `char_out` stays stable while stalled, and the frame takes 32 cycles.
- Mid-frame change:
  - Stimulus: `OLED_data` changes 0x1 → 0x2 at column 5, then 0x2 → 0x3 at column 9.
  - Required: the first frame prints 0x00000001, followed by exactly one frame printing 0x00000003.
- Non-printable opcode: 0x6E6F6F70 ("noop") prints unchanged; 0x0A7F4142 prints "\x20\x20AB".
- Reset at column 8: `char_valid` is 0 the next cycle and no `frame_done` is pulsed. A fresh frame then starts from column 0.
